// File: rtl/ps2_pkg.sv
// Shared constants and state encodings for the PS/2 keycode receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {FrmIdle, FrmData, FrmParity, FrmStop} frame_state_e;

  typedef enum logic [1:0] {PfxNone, PfxExt, PfxBrk, PfxExtBrk} prefix_state_e;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// Conditions the PS/2 lines and deframes 11-bit frames into bytes, flagging bad or stalled frames.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]      sync1_q, sync2_q, filt_q;
  logic [CntW-1:0] cnt_q [2];
  logic            kclk_prev_q;
  logic            fe, din;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      filt_q      <= '1;
      kclk_prev_q <= 1'b1;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
    end else begin
      sync1_q     <= {kdata, kclk};
      sync2_q     <= sync1_q;
      kclk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign fe  = kclk_prev_q & ~filt_q[0];
  assign din = filt_q[1];

  frame_state_e    state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FrmIdle;
      bitcnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tmo_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tmo_q    <= tmo_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tmo_d    = tmo_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      FrmIdle: begin
        tmo_d = '0;
        if (fe) begin
          if (!din) begin
            state_d  = FrmData;
            bitcnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FrmData: begin
        if (fe) begin
          shift_d  = {din, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = FrmParity;
        end
      end
      FrmParity: begin
        if (fe) begin
          parity_d = din;
          state_d  = FrmStop;
        end
      end
      FrmStop: begin
        if (fe) begin
          if (din && odd_parity_ok(shift_q, parity_q)) valid_d = 1'b1;
          else err_d = 1'b1;
          state_d = FrmIdle;
        end
      end
      default: state_d = FrmIdle;
    endcase
    // Mid-frame watchdog: restarts on every falling edge.
    if (state_q != FrmIdle) begin
      if (fe) begin
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        state_d = FrmIdle;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard front end: strips E0/F0 prefixes and reports make/break codes as one-cycle pulses.
module ps2_keycode_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       Clock,
  input  logic       btnCpuReset,
  input  logic       KClock,
  input  logic       KData,
  output logic [7:0] KeyCode,
  output logic       Flag,
  output logic       Release,
  output logic       Extended,
  output logic       FrameErr
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (Clock),
    .rst       (btnCpuReset),
    .kclk      (KClock),
    .kdata     (KData),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  prefix_state_e pfx_q, pfx_d;
  logic [7:0]    code_d;
  logic          flag_d, rel_d, ext_d;
  logic          ext_pend, brk_pend;

  assign ext_pend = (pfx_q == PfxExt) || (pfx_q == PfxExtBrk);
  assign brk_pend = (pfx_q == PfxBrk) || (pfx_q == PfxExtBrk);

  always_ff @(posedge Clock) begin
    if (btnCpuReset) begin
      pfx_q    <= PfxNone;
      KeyCode  <= 8'h00;
      Flag     <= 1'b0;
      Release  <= 1'b0;
      Extended <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      pfx_q    <= pfx_d;
      KeyCode  <= code_d;
      Flag     <= flag_d;
      Release  <= rel_d;
      Extended <= ext_d;
      FrameErr <= frame_err;
    end
  end

  always_comb begin
    pfx_d  = pfx_q;
    code_d = KeyCode;
    flag_d = 1'b0;
    rel_d  = 1'b0;
    ext_d  = Extended;
    if (frame_err) begin
      pfx_d = PfxNone;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        pfx_d = brk_pend ? PfxExtBrk : PfxExt;
      end else if (rx_byte == PS2_BREAK) begin
        pfx_d = ext_pend ? PfxExtBrk : PfxBrk;
      end else begin
        code_d = rx_byte;
        ext_d  = ext_pend;
        rel_d  = brk_pend;
        flag_d = ~brk_pend;
        pfx_d  = PfxNone;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Scoreboard bench: frame sender pushes expected key events, a monitor pops them as the DUT pulses.
module tb_ps2_keycode_receiver;

  localparam int H = 15;  // PS/2 half-period in system clocks

  logic       Clock = 1'b0;
  logic       btnCpuReset = 1'b1;
  logic       KClock = 1'b1;
  logic       KData = 1'b1;
  logic [7:0] KeyCode;
  logic       Flag, Release, Extended, FrameErr;

  ps2_keycode_receiver dut (
    .Clock      (Clock),
    .btnCpuReset(btnCpuReset),
    .KClock     (KClock),
    .KData      (KData),
    .KeyCode    (KeyCode),
    .Flag       (Flag),
    .Release    (Release),
    .Extended   (Extended),
    .FrameErr   (FrameErr)
  );

  always #5 Clock = ~Clock;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned ferr_seen = 0;
  int unsigned exp_ferr = 0;
  logic [9:0]  exp_q[$];  // {release, extended, code}
  bit          mdl_ext = 0, mdl_brk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  logic [7:0] held_code = 8'h00;
  bit         prev_pulse = 0;
  always @(negedge Clock) begin
    logic [9:0] e;
    if (btnCpuReset) begin
      held_code  = 8'h00;
      prev_pulse = 0;
    end else begin
      if (Flag && Release) check("flag_and_release", 32'(Flag & Release), 32'd0);
      if (Flag || Release) begin
        if (prev_pulse) check("pulse_width", 32'(prev_pulse), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_event", {22'd0, Release, Extended, KeyCode}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("release", 32'(Release), 32'(e[9]));
          check("extended", 32'(Extended), 32'(e[8]));
          check("keycode", 32'(KeyCode), 32'(e[7:0]));
          held_code = e[7:0];
        end
      end else begin
        check("held_keycode", 32'(KeyCode), 32'(held_code));
      end
      if (FrameErr) ferr_seen++;
      prev_pulse = Flag | Release;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    KData = b;
    cycles(H);
    KClock = 1'b0;
    cycles(H);
    KClock = 1'b1;
  endtask

  // Reference model: byte-level prefix rules, applied as the frame is issued.
  task automatic send_frame(input logic [7:0] b, input bit bad_parity);
    logic par;
    if (bad_parity) begin
      exp_ferr++;
      mdl_ext = 0;
      mdl_brk = 0;
    end else if (b == 8'hE0) begin
      mdl_ext = 1;
    end else if (b == 8'hF0) begin
      mdl_brk = 1;
    end else begin
      exp_q.push_back({mdl_brk, mdl_ext, b});
      mdl_ext = 0;
      mdl_brk = 0;
    end
    par = ~(^b) ^ bad_parity;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    cycles(4 * H);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge Clock);
    cycles(40);
    check({name, "_pending_events"}, exp_q.size(), 32'd0);
    check({name, "_frame_errs"}, ferr_seen, exp_ferr);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_keycode"}, 32'(KeyCode), 32'h00);
    check({name, "_pulses"}, {28'd0, Flag, Release, Extended, FrameErr}, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int r;
    cycles(4);
    check_reset_outputs("reset");
    btnCpuReset = 1'b0;
    cycles(20);

    send_frame(8'h24, 0);
    drain("make_24");

    send_frame(8'hF0, 0);
    send_frame(8'h24, 0);
    drain("break_24");

    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    drain("ext_75");

    send_frame(8'h0D, 1);
    drain("bad_parity");
    send_frame(8'h0D, 0);
    drain("good_0d");

    b = 8'h0D;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    exp_ferr++;
    mdl_ext = 0;
    mdl_brk = 0;
    cycles(25000);
    check("timeout_errs", ferr_seen, exp_ferr);
    send_frame(8'h0D, 0);
    drain("after_timeout");

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else b = 8'($urandom);
      send_frame(b, $urandom_range(0, 9) == 0);
    end
    drain("random");

    // Reset in the middle of a frame, with an E0 prefix pending.
    send_frame(8'hE0, 0);
    b = 8'h24;
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(b[i]);
    btnCpuReset = 1'b1;
    cycles(1);
    check_reset_outputs("mid_reset");
    btnCpuReset = 1'b0;
    mdl_ext = 0;
    mdl_brk = 0;
    send_bit(b[6]);
    send_bit(b[7]);
    send_bit(1'b1);
    send_bit(1'b1);
    exp_ferr++;  // stray edges form a partial frame that times out
    cycles(22000);
    send_frame(8'h1C, 0);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
